unified_mem_arbiter: RTL

Shares one single-port unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester of the 5-stage pipeline. It arbitrates with data-first priority plus a fetch anti-starvation counter. It sequences a fixed-latency memory access and returns registered read data with a valid pulse. It drives per-stage stall outputs, which the hazard unit ORs into PCWrite/IFIDWrite and pipeline-register enables.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_priority_sel.sv | 13 +
 rtl/unified_mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_D  = 1'b1
  } req_sel_e;

  // Width of a counter that must hold values 0..maxval inclusive.
  function automatic int cnt_w(input int maxval);
    return $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Data-first priority select; fetch wins only when it has been starved long enough.
module arb_priority_sel (
  input  logic d_req,
  input  logic if_req,
  input  logic starve_sat,
  output logic grant_if,
  output logic grant_d
);

  assign grant_d  = d_req & (~starve_sat | ~if_req);
  assign grant_if = if_req & ~grant_d;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, one fixed-latency
// access at a time; grant in IDLE, MEM_LAT enable cycles, registered data + valid after.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam int LAT_W = cnt_w(MEM_LAT);
  localparam int ST_W  = cnt_w(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_FIRST = LAT_W'(1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);

  arb_state_e state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic     idle;
  logic     arb_en;
  logic     last_acc;
  logic     starve_sat;
  logic     grant_if;
  logic     grant_d;
  req_sel_e sel;

  assign idle       = (state_q == IDLE);
  // Grants are suppressed while reset is held so no requester sees a phantom accept.
  assign arb_en     = idle & nreset;
  assign last_acc   = ~idle & (lat_q == LAT_LAST);
  assign starve_sat = (starve_q >= ST_MAX);

  arb_priority_sel u_prio (
    .d_req      (d_req),
    .if_req     (if_req),
    .starve_sat (starve_sat),
    .grant_if   (grant_if),
    .grant_d    (grant_d)
  );

  assign if_gnt = arb_en & grant_if;
  assign d_gnt  = arb_en & grant_d;
  assign sel    = grant_d ? SEL_D : SEL_IF;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_gnt | d_gnt) begin
          lat_d = LAT_FIRST;
          if (sel == SEL_D) begin
            state_d = ACC_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            state_d = ACC_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
          end
        end
      end
      ACC_IF, ACC_D: begin
        if (last_acc) begin
          state_d = IDLE;
          lat_d   = '0;
          if (state_q == ACC_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // A fetch is only counted as waiting when it is neither accepted nor just completing.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (if_req && !if_valid_q && !starve_sat) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lat_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign mem_en    = ~idle;
  assign mem_we    = (state_q == ACC_D) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;

  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;
  assign busy      = ~idle;

endmodule
